// File: rtl/ise_pkg.sv
// Shared constants and state encoding for the ISE pixel-input transmit path.
// Words are packed as {index[28:24], pixel[23:0]}.
package ise_pkg;

   localparam int DEFAULT_IMAGE_NUM  = 32;
   localparam int DEFAULT_IMAGE_SIZE = 128;
   localparam int IDX_W              = 5;
   localparam int PIX_W              = 24;
   localparam int WORD_W             = IDX_W + PIX_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/ise_prefetch_fifo.sv
// Two-entry prefetch buffer for words returning from image memory.
// Push and pop may occur on the same edge; the head is always visible on dout.
module ise_prefetch_fifo
   import ise_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [WORD_W-1:0] din,
   output logic [WORD_W-1:0] dout,
   output logic [1:0]        count
);

   logic [WORD_W-1:0] mem_r [2];
   logic              wr_ptr_r;
   logic              rd_ptr_r;
   logic [1:0]        count_r;

   // Storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_r[0] <= {WORD_W{1'b0}};
         mem_r[1] <= {WORD_W{1'b0}};
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (push) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= ~wr_ptr_r;
         end
         if (pop) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   assign dout  = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/ise_pixel_feeder.sv
// Streams packed pixel words from synchronous image memory into the ISE core,
// in address order, honouring busy backpressure through a 2-entry prefetch.
module ise_pixel_feeder
   import ise_pkg::*;
#(
   parameter int  IMAGE_NUM  = DEFAULT_IMAGE_NUM,
   parameter int  IMAGE_SIZE = DEFAULT_IMAGE_SIZE,
   localparam int TOTAL      = IMAGE_NUM * IMAGE_SIZE * IMAGE_SIZE,
   localparam int AW         = $clog2(TOTAL)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              mem_rd,
   output logic [AW-1:0]     mem_addr,
   input  logic [WORD_W-1:0] mem_rdata,
   input  logic              busy,
   output logic              pixel_valid,
   output logic [IDX_W-1:0]  image_in_index,
   output logic [PIX_W-1:0]  pixel_in,
   output logic              done
);

   localparam logic [AW:0] TOTAL_W = (AW+1)'(TOTAL);
   localparam logic [AW:0] LAST_W  = (AW+1)'(TOTAL - 1);
   localparam logic [AW:0] ONE_W   = (AW+1)'(1);

   state_t            state_r, state_s;
   logic [AW:0]       rd_ptr_r, sent_r;
   logic              inflight_r;
   logic              pixel_valid_r, done_r;
   logic [IDX_W-1:0]  index_r;
   logic [PIX_W-1:0]  pixel_r;

   logic [1:0]        fifo_count_s;
   logic [WORD_W-1:0] fifo_dout_s, src_s;
   logic [2:0]        occ_s;
   logic              mem_rd_s, xfer_s, load_s, avail_s, last_xfer_s, start_run_s;
   logic              fifo_push_s, fifo_pop_s, bypass_s;

   ise_prefetch_fifo u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push_s),
      .pop   (fifo_pop_s),
      .din   (mem_rdata),
      .dout  (fifo_dout_s),
      .count (fifo_count_s)
   );

   // Read issue, handshake and output-register source selection.
   always_comb begin
      occ_s       = {1'b0, fifo_count_s} + {2'b00, inflight_r};
      mem_rd_s    = (state_r == STREAM) && (rd_ptr_r < TOTAL_W) && (occ_s < 3'd2);
      xfer_s      = pixel_valid_r && !busy;
      load_s      = !pixel_valid_r || xfer_s;
      avail_s     = (fifo_count_s != 2'd0) || inflight_r;
      // The FIFO head is older than a returning word, so it always wins.
      src_s       = (fifo_count_s != 2'd0) ? fifo_dout_s : mem_rdata;
      fifo_pop_s  = load_s && (fifo_count_s != 2'd0);
      bypass_s    = load_s && (fifo_count_s == 2'd0) && inflight_r;
      fifo_push_s = inflight_r && !bypass_s;
      last_xfer_s = xfer_s && (sent_r == LAST_W);
      start_run_s = ((state_r == IDLE) || (state_r == DONE)) && start;
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_s = STREAM;
            else       state_s = IDLE;
         end
         STREAM: begin
            if (last_xfer_s)                           state_s = DONE;
            else if (mem_rd_s && (rd_ptr_r == LAST_W)) state_s = DRAIN;
            else                                       state_s = STREAM;
         end
         DRAIN: begin
            if (last_xfer_s) state_s = DONE;
            else             state_s = DRAIN;
         end
         DONE: begin
            if (start) state_s = STREAM;
            else       state_s = DONE;
         end
         default: state_s = IDLE;
      endcase
   end

   // State, counters, in-flight tracking and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= IDLE;
         rd_ptr_r      <= {(AW+1){1'b0}};
         sent_r        <= {(AW+1){1'b0}};
         inflight_r    <= 1'b0;
         pixel_valid_r <= 1'b0;
         index_r       <= {IDX_W{1'b0}};
         pixel_r       <= {PIX_W{1'b0}};
         done_r        <= 1'b0;
      end else begin
         state_r    <= state_s;
         inflight_r <= mem_rd_s;
         if (start_run_s) begin
            rd_ptr_r <= {(AW+1){1'b0}};
            sent_r   <= {(AW+1){1'b0}};
         end else begin
            if (mem_rd_s) rd_ptr_r <= rd_ptr_r + ONE_W;
            if (xfer_s)   sent_r   <= sent_r + ONE_W;
         end
         if (last_xfer_s)      done_r <= 1'b1;
         else if (start_run_s) done_r <= 1'b0;
         if (last_xfer_s) begin
            pixel_valid_r <= 1'b0;
         end else if (load_s) begin
            pixel_valid_r <= avail_s;
            if (avail_s) begin
               index_r <= src_s[WORD_W-1:PIX_W];
               pixel_r <= src_s[PIX_W-1:0];
            end
         end
      end
   end

   assign mem_rd         = mem_rd_s;
   assign mem_addr       = rd_ptr_r[AW-1:0];
   assign pixel_valid    = pixel_valid_r;
   assign image_in_index = index_r;
   assign pixel_in       = pixel_r;
   assign done           = done_r;

endmodule

// File: tb/tb_ise_pixel_feeder.sv
// Directed bench for ise_pixel_feeder at IMAGE_NUM=2, IMAGE_SIZE=2 (8 words),
// with a synchronous memory model and a transfer monitor.
module tb_ise_pixel_feeder;

   localparam int IMAGE_NUM  = 2;
   localparam int IMAGE_SIZE = 2;
   localparam int TOTAL      = 8;
   localparam int AW         = 3;

   logic          clk = 1'b0;
   logic          reset, start, busy;
   logic          mem_rd, pixel_valid, done;
   logic [AW-1:0] mem_addr;
   logic [28:0]   mem_rdata;
   logic [4:0]    image_in_index;
   logic [23:0]   pixel_in;

   int errors = 0;
   int checks = 0;

   logic [28:0] mem [TOTAL];
   logic [28:0] xfer_q [$];
   int          rd_cnt, xfer_cnt, ovf_cnt, hold_err;
   logic        prev_stall;
   logic [28:0] prev_word;

   ise_pixel_feeder #(.IMAGE_NUM(IMAGE_NUM), .IMAGE_SIZE(IMAGE_SIZE)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .mem_rd         (mem_rd),
      .mem_addr       (mem_addr),
      .mem_rdata      (mem_rdata),
      .busy           (busy),
      .pixel_valid    (pixel_valid),
      .image_in_index (image_in_index),
      .pixel_in       (pixel_in),
      .done           (done)
   );

   always #5 clk = ~clk;

   function automatic logic [28:0] exp_word(input int k);
      logic [4:0]  idx;
      logic [23:0] pix;
      idx = 5'(k);
      pix = 24'hA00000 + 24'(k);
      return {idx, pix};
   endfunction

   // Synchronous memory; a poison value appears when no read was issued.
   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem[mem_addr];
      else        mem_rdata <= 29'h1FFFFFFF;
   end

   // Transfer monitor: order log, read-occupancy model, hold-under-busy check.
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (pixel_valid !== 1'b1 || {image_in_index, pixel_in} !== prev_word))
            hold_err++;
         if (mem_rd === 1'b1) begin
            if (rd_cnt - xfer_cnt - (pixel_valid ? 1 : 0) >= 2) ovf_cnt++;
            rd_cnt++;
         end
         if (pixel_valid === 1'b1 && busy === 1'b0) begin
            xfer_q.push_back({image_in_index, pixel_in});
            xfer_cnt++;
         end
         prev_stall = (pixel_valid === 1'b1) && busy;
         prev_word  = {image_in_index, pixel_in};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      xfer_q.delete();
      rd_cnt   = 0;
      xfer_cnt = 0;
      ovf_cnt  = 0;
      hold_err = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; busy = 1'b0;
      repeat (3) tick();
      checks++;
      if (pixel_valid !== 1'b0 || done !== 1'b0 || image_in_index !== 5'd0 || pixel_in !== 24'd0)
         begin errors++; $display("FAIL reset_outputs: got pv=%b done=%b idx=%h pix=%h, need all 0",
                                  pixel_valid, done, image_in_index, pixel_in); end
      checks++;
      if (mem_rd !== 1'b0 || mem_addr !== 3'd0)
         begin errors++; $display("FAIL reset_mem: got rd=%b addr=%0d, need 0/0", mem_rd, mem_addr); end
      reset = 1'b0;
      tick(); tick();
      checks++;
      if (pixel_valid !== 1'b0 || mem_rd !== 1'b0)
         begin errors++; $display("FAIL idle_quiet: got pv=%b rd=%b, need 0/0", pixel_valid, mem_rd); end
   endtask

   task automatic test_stream();
      bit bad;
      clear_mon();
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if (mem_rd !== 1'b1 || mem_addr !== 3'd0 || pixel_valid !== 1'b0)
         begin errors++; $display("FAIL first_read: got rd=%b addr=%0d pv=%b, need 1/0/0", mem_rd, mem_addr, pixel_valid); end
      tick();
      checks++;
      if (mem_rd !== 1'b1 || mem_addr !== 3'd1 || pixel_valid !== 1'b0)
         begin errors++; $display("FAIL second_read: got rd=%b addr=%0d pv=%b, need 1/1/0", mem_rd, mem_addr, pixel_valid); end
      tick();
      for (int k = 0; k < TOTAL; k++) begin
         checks++;
         if (pixel_valid !== 1'b1 || {image_in_index, pixel_in} !== exp_word(k))
            begin errors++; $display("FAIL stream_word%0d: got pv=%b word=%h, need 1/%h", k, pixel_valid, {image_in_index, pixel_in}, exp_word(k)); end
         tick();
      end
      checks++;
      if (done !== 1'b1 || pixel_valid !== 1'b0 || mem_rd !== 1'b0)
         begin errors++; $display("FAIL stream_done: got done=%b pv=%b rd=%b, need 1/0/0", done, pixel_valid, mem_rd); end
      tick(); tick();
      checks++;
      if (done !== 1'b1 || pixel_valid !== 1'b0)
         begin errors++; $display("FAIL done_level: got done=%b pv=%b, need 1/0", done, pixel_valid); end
      bad = (xfer_cnt != TOTAL) || (rd_cnt != TOTAL);
      for (int i = 0; i < xfer_q.size() && i < TOTAL; i++) if (xfer_q[i] !== exp_word(i)) bad = 1'b1;
      checks++;
      if (bad)
         begin errors++; $display("FAIL stream_count: got xfers=%0d reads=%0d (or bad order), need 8/8", xfer_cnt, rd_cnt); end
   endtask

   task automatic test_busy();
      bit bad;
      int c;
      clear_mon();
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if (done !== 1'b0)
         begin errors++; $display("FAIL done_clear: got done=%b, need 0", done); end
      c = 1;
      while (done !== 1'b1 && c < 100) begin
         busy = ((c >= 9 && c <= 12) || (c % 2 == 1)) ? 1'b1 : 1'b0;
         tick();
         c++;
      end
      busy = 1'b0;
      checks++;
      if (done !== 1'b1)
         begin errors++; $display("FAIL busy_timeout: got done=%b after %0d cycles, need 1", done, c); end
      bad = (xfer_cnt != TOTAL) || (xfer_q.size() != TOTAL);
      for (int i = 0; i < xfer_q.size() && i < TOTAL; i++) if (xfer_q[i] !== exp_word(i)) bad = 1'b1;
      checks++;
      if (bad)
         begin errors++; $display("FAIL busy_order: got %0d xfers (or bad order), need words 0..7 once", xfer_cnt); end
      checks++;
      if (ovf_cnt != 0 || hold_err != 0 || rd_cnt != TOTAL)
         begin errors++; $display("FAIL busy_flow: got ovf=%0d hold=%0d reads=%0d, need 0/0/8", ovf_cnt, hold_err, rd_cnt); end
   endtask

   task automatic test_long_busy();
      bit bad;
      clear_mon();
      start = 1'b1; tick(); start = 1'b0;
      busy = 1'b1;
      tick(); tick();
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (pixel_valid !== 1'b1 || {image_in_index, pixel_in} !== exp_word(0)) bad = 1'b1;
         if (i < 19) tick();
      end
      checks++;
      if (bad)
         begin errors++; $display("FAIL long_hold: got pv=%b word=%h, need word0 held 20 cycles", pixel_valid, {image_in_index, pixel_in}); end
      checks++;
      if (rd_cnt != 3 || mem_rd !== 1'b0)
         begin errors++; $display("FAIL long_reads: got reads=%0d rd=%b, need 3/0", rd_cnt, mem_rd); end
      busy = 1'b0;
      for (int k = 1; k < TOTAL; k++) begin
         tick();
         checks++;
         if (pixel_valid !== 1'b1 || {image_in_index, pixel_in} !== exp_word(k))
            begin errors++; $display("FAIL release_word%0d: got pv=%b word=%h, need 1/%h", k, pixel_valid, {image_in_index, pixel_in}, exp_word(k)); end
      end
      tick();
      checks++;
      if (done !== 1'b1 || xfer_cnt != TOTAL || ovf_cnt != 0 || hold_err != 0)
         begin errors++; $display("FAIL long_done: got done=%b xfers=%0d ovf=%0d hold=%0d, need 1/8/0/0", done, xfer_cnt, ovf_cnt, hold_err); end
   endtask

   task automatic test_reset_mid();
      clear_mon();
      busy = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      repeat (5) tick();
      checks++;
      if (pixel_valid !== 1'b1 || {image_in_index, pixel_in} !== exp_word(3) || xfer_cnt != 3)
         begin errors++; $display("FAIL mid_pre: got pv=%b word=%h xfers=%0d, need 1/%h/3", pixel_valid, {image_in_index, pixel_in}, xfer_cnt, exp_word(3)); end
      reset = 1'b1; tick();
      checks++;
      if (pixel_valid !== 1'b0 || done !== 1'b0 || image_in_index !== 5'd0 || pixel_in !== 24'd0 || mem_rd !== 1'b0 || mem_addr !== 3'd0)
         begin errors++; $display("FAIL mid_reset: got pv=%b done=%b idx=%h pix=%h rd=%b addr=%0d, need all 0",
                                  pixel_valid, done, image_in_index, pixel_in, mem_rd, mem_addr); end
      reset = 1'b0;
      tick(); tick();
      checks++;
      if (pixel_valid !== 1'b0 || mem_rd !== 1'b0 || done !== 1'b0)
         begin errors++; $display("FAIL mid_quiet: got pv=%b rd=%b done=%b, need 0/0/0", pixel_valid, mem_rd, done); end
      clear_mon();
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if (mem_rd !== 1'b1 || mem_addr !== 3'd0)
         begin errors++; $display("FAIL replay_addr: got rd=%b addr=%0d, need 1/0", mem_rd, mem_addr); end
      tick(); tick();
      for (int k = 0; k < TOTAL; k++) begin
         checks++;
         if (pixel_valid !== 1'b1 || {image_in_index, pixel_in} !== exp_word(k))
            begin errors++; $display("FAIL replay_word%0d: got pv=%b word=%h, need 1/%h", k, pixel_valid, {image_in_index, pixel_in}, exp_word(k)); end
         tick();
      end
      checks++;
      if (done !== 1'b1 || xfer_cnt != TOTAL)
         begin errors++; $display("FAIL replay_done: got done=%b xfers=%0d, need 1/8", done, xfer_cnt); end
   endtask

   task automatic test_restart();
      bit bad;
      clear_mon();
      start = 1'b1; tick();
      checks++;
      if (done !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 3'd0)
         begin errors++; $display("FAIL restart1_begin: got done=%b rd=%b addr=%0d, need 0/1/0", done, mem_rd, mem_addr); end
      repeat (10) tick();
      checks++;
      if (done !== 1'b1 || pixel_valid !== 1'b0)
         begin errors++; $display("FAIL restart1_done: got done=%b pv=%b, need 1/0", done, pixel_valid); end
      tick();
      checks++;
      if (done !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 3'd0)
         begin errors++; $display("FAIL restart2_begin: got done=%b rd=%b addr=%0d, need 0/1/0", done, mem_rd, mem_addr); end
      tick(); tick();
      for (int k = 0; k < TOTAL; k++) begin
         checks++;
         if (pixel_valid !== 1'b1 || {image_in_index, pixel_in} !== exp_word(k))
            begin errors++; $display("FAIL restart2_word%0d: got pv=%b word=%h, need 1/%h", k, pixel_valid, {image_in_index, pixel_in}, exp_word(k)); end
         tick();
      end
      start = 1'b0;
      checks++;
      if (done !== 1'b1)
         begin errors++; $display("FAIL restart2_done: got done=%b, need 1", done); end
      tick(); tick();
      bad = (xfer_cnt != 2 * TOTAL) || (done !== 1'b1) || (pixel_valid !== 1'b0);
      for (int i = 0; i < xfer_q.size() && i < 2 * TOTAL; i++) if (xfer_q[i] !== exp_word(i % TOTAL)) bad = 1'b1;
      checks++;
      if (bad)
         begin errors++; $display("FAIL restart_total: got xfers=%0d done=%b pv=%b (or bad order), need 16/1/0", xfer_cnt, done, pixel_valid); end
   endtask

   initial begin
      for (int i = 0; i < TOTAL; i++) mem[i] = exp_word(i);
      clear_mon();
      prev_stall = 1'b0;
      prev_word  = 29'd0;
      test_reset();
      test_stream();
      test_busy();
      test_long_busy();
      test_reset_mid();
      test_restart();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit, need completion");
      $fatal(1, "watchdog expired");
   end

endmodule
